// File: rtl/txfifo_pkg.sv
// Shared constants and pointer arithmetic helpers for the store-and-forward TX FIFO.
package txfifo_pkg;

   localparam int DEF_WIDTH    = 256;
   localparam int DEF_DEPTH    = 1024;
   localparam int DEF_PTR      = 10;
   localparam int DEF_AFULL_TH = 992;
   // The EOP flag sits just above the data bits in each stored word
   localparam int EOP_BIT      = DEF_WIDTH;

   // Difference of two wrapping pointers, reduced to ptr_w+1 bits
   function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          ptr_w);
      logic [31:0] mask;
      mask = (32'd1 << (ptr_w + 1)) - 32'd1;
      return (a - b) & mask;
   endfunction

   function automatic logic level_at_or_above(input logic [31:0] level,
                                              input logic [31:0] th);
      return (level >= th);
   endfunction

endpackage

// File: rtl/txfifo_pkt_sf_if.sv
// Write/read bus of the packet FIFO; master is the host/MAC side, slave is the FIFO.
interface txfifo_pkt_sf_if
   import txfifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int PTR   = DEF_PTR
);
   logic             wrreq;
   logic [WIDTH-1:0] data;
   logic             wreop;
   logic             wrabort;
   logic             wrfull;
   logic             wrafull;
   logic [PTR:0]     wrusedw;
   logic             wrdrop;
   logic             rdreq;
   logic [WIDTH-1:0] q;
   logic             rdeop;
   logic             rdempty;
   logic [PTR:0]     pktcnt;

   modport master (
      output wrreq, data, wreop, wrabort, rdreq,
      input  wrfull, wrafull, wrusedw, wrdrop, q, rdeop, rdempty, pktcnt
   );

   modport slave (
      input  wrreq, data, wreop, wrabort, rdreq,
      output wrfull, wrafull, wrusedw, wrdrop, q, rdeop, rdempty, pktcnt
   );
endinterface

// File: rtl/txfifo_sdp_ram.sv
// Single-clock simple dual-port RAM with a registered read port (output register resets to 0).
module txfifo_sdp_ram
   import txfifo_pkg::*;
#(
   parameter int W     = DEF_WIDTH + 1,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_PTR
) (
   input  logic          clk,
   input  logic          reset_,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)  rdata <= '0;
      else if (re)  rdata <= mem[raddr];
   end

endmodule

// File: rtl/txfifo_pkt_sf.sv
// Store-and-forward TX FIFO: reader only sees committed packets; aborts roll back to the commit point.
// Optional oversize-packet drop is compiled in with `define TXFIFO_PKT_DROP_EN.
module txfifo_pkt_sf
   import txfifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int PTR      = DEF_PTR,
   parameter int AFULL_TH = DEF_AFULL_TH
) (
   input  logic           clk,
   input  logic           reset_,
   txfifo_pkt_sf_if.slave bus
);

   localparam int PW = PTR + 1;

   logic [PW-1:0]    wr_ptr, cm_ptr, rd_ptr, pktcnt_r, used;
   logic [DEPTH-1:0] eop_flags;
   logic [WIDTH:0]   rd_word;
   logic             full, empty, wr_en, rd_en, commit, eop_rd, drop, wrdrop_r;

   assign used   = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PTR));
   assign full   = (used == PW'(DEPTH));
   assign empty  = (rd_ptr == cm_ptr);
   assign wr_en  = bus.wrreq & ~full & ~bus.wrabort;
   assign rd_en  = bus.rdreq & ~empty;
   assign commit = wr_en & bus.wreop;
   // Side copy of the EOP bits lets pktcnt drop in the same cycle the EOP word is read
   assign eop_rd = rd_en & eop_flags[rd_ptr[PTR-1:0]];

`ifdef TXFIFO_PKT_DROP_EN
   logic ovf, ovf_hit;

   // Full with nothing committed means one packet has outgrown the whole buffer
   assign ovf_hit = bus.wrreq & full & (pktcnt_r == '0);
   assign drop    = bus.wrabort | ((ovf | ovf_hit) & bus.wrreq & bus.wreop);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)       ovf <= 1'b0;
      else if (drop)     ovf <= 1'b0;
      else if (ovf_hit)  ovf <= 1'b1;
   end
`else
   assign drop = bus.wrabort;
`endif

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wr_ptr   <= '0;
         cm_ptr   <= '0;
         rd_ptr   <= '0;
         pktcnt_r <= '0;
         wrdrop_r <= 1'b0;
      end else begin
         if (drop) begin
            wr_ptr <= cm_ptr;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (bus.wreop) cm_ptr <= wr_ptr + PW'(1);
         end
         if (rd_en) rd_ptr <= rd_ptr + PW'(1);
         if (commit && !eop_rd)      pktcnt_r <= pktcnt_r + PW'(1);
         else if (!commit && eop_rd) pktcnt_r <= pktcnt_r - PW'(1);
         wrdrop_r <= drop;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) eop_flags[wr_ptr[PTR-1:0]] <= bus.wreop;
   end

   txfifo_sdp_ram #(
      .W     (WIDTH + 1),
      .DEPTH (DEPTH),
      .AW    (PTR)
   ) u_ram (
      .clk    (clk),
      .reset_ (reset_),
      .we     (wr_en),
      .waddr  (wr_ptr[PTR-1:0]),
      .wdata  ({bus.wreop, bus.data}),
      .re     (rd_en),
      .raddr  (rd_ptr[PTR-1:0]),
      .rdata  (rd_word)
   );

   assign bus.q       = rd_word[WIDTH-1:0];
   assign bus.rdeop   = rd_word[WIDTH];
   assign bus.rdempty = empty;
   assign bus.wrfull  = full;
   assign bus.wrafull = level_at_or_above(32'(used), 32'(AFULL_TH));
   assign bus.wrusedw = used;
   assign bus.wrdrop  = wrdrop_r;
   assign bus.pktcnt  = pktcnt_r;

endmodule

// File: tb/tb_txfifo_pkt_sf.sv
// Scoreboard bench for txfifo_pkt_sf: packets, aborts, full/afull, oversize, wraparound, async reset.
module tb_txfifo_pkt_sf;
   localparam int WIDTH = 256, DEPTH = 1024, PTR = 10, AFULL_TH = 992;

   logic clk = 1'b0;
   logic reset_ = 1'b0;
   int total = 0;
   int bad = 0;
   logic [WIDTH:0] sb[$];
   logic [WIDTH:0] exp_w;

   txfifo_pkt_sf_if #(.WIDTH(WIDTH), .PTR(PTR)) bus ();

   txfifo_pkt_sf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR), .AFULL_TH(AFULL_TH)) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] rnd_word();
      logic [WIDTH-1:0] w;
      for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic idle();
      bus.wrreq = 0; bus.wreop = 0; bus.wrabort = 0; bus.rdreq = 0; bus.data = '0;
   endtask

   // One write cycle; expected-accepted words go to the scoreboard
   task automatic put(input logic eop, input logic accept);
      bus.wrreq = 1; bus.wreop = eop; bus.data = rnd_word();
      if (accept) sb.push_back({eop, bus.data});
      cyc();
      bus.wrreq = 0; bus.wreop = 0;
   endtask

   task automatic test_reset();
      idle();
      reset_ = 0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus.q !== '0)       begin bad++; $display("FAIL reset_q got=%h want=0", bus.q); end
      total++; if (bus.rdeop !== 1'b0) begin bad++; $display("FAIL reset_rdeop got=%b want=0", bus.rdeop); end
      total++; if (bus.rdempty !== 1'b1) begin bad++; $display("FAIL reset_rdempty got=%b want=1", bus.rdempty); end
      total++; if (bus.wrfull !== 1'b0) begin bad++; $display("FAIL reset_wrfull got=%b want=0", bus.wrfull); end
      total++; if (bus.wrafull !== 1'b0) begin bad++; $display("FAIL reset_wrafull got=%b want=0", bus.wrafull); end
      total++; if (bus.wrusedw !== '0) begin bad++; $display("FAIL reset_wrusedw got=%0d want=0", bus.wrusedw); end
      total++; if (bus.pktcnt !== '0)  begin bad++; $display("FAIL reset_pktcnt got=%0d want=0", bus.pktcnt); end
      total++; if (bus.wrdrop !== 1'b0) begin bad++; $display("FAIL reset_wrdrop got=%b want=0", bus.wrdrop); end
      reset_ = 1;
      cyc();
   endtask

   task automatic test_basic_packet();
      for (int i = 0; i < 4; i++) begin
         put(i == 3, 1);
         total++;
         if (bus.rdempty !== (i < 3)) begin bad++; $display("FAIL basic_rdempty w%0d got=%b want=%b", i, bus.rdempty, i < 3); end
         total++;
         if (bus.pktcnt !== ((i == 3) ? 11'd1 : 11'd0)) begin bad++; $display("FAIL basic_pktcnt w%0d got=%0d", i, bus.pktcnt); end
      end
      bus.rdreq = 1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         exp_w = sb.pop_front();
         total++;
         if ({bus.rdeop, bus.q} !== exp_w) begin bad++; $display("FAIL basic_q r%0d got=%h want=%h", i, {bus.rdeop, bus.q}, exp_w); end
         total++;
         if (bus.pktcnt !== ((i == 3) ? 11'd0 : 11'd1)) begin bad++; $display("FAIL basic_pktcnt_rd r%0d got=%0d", i, bus.pktcnt); end
      end
      bus.rdreq = 0;
      total++; if (bus.rdempty !== 1'b1) begin bad++; $display("FAIL basic_empty_end got=%b want=1", bus.rdempty); end
      cyc();
      total++; if ({bus.rdeop, bus.q} !== exp_w) begin bad++; $display("FAIL basic_q_hold got=%h want=%h", {bus.rdeop, bus.q}, exp_w); end
   endtask

   task automatic test_abort();
      int drops;
      drops = 0;
      for (int i = 0; i < 3; i++) put(1'b0, 1'b0);
      total++; if (bus.wrusedw !== 11'd3) begin bad++; $display("FAIL abort_used3 got=%0d want=3", bus.wrusedw); end
      bus.wrabort = 1; cyc(); bus.wrabort = 0;
      if (bus.wrdrop === 1'b1) drops++;
      total++; if (bus.wrusedw !== 11'd0) begin bad++; $display("FAIL abort_used0 got=%0d want=0", bus.wrusedw); end
      cyc();
      if (bus.wrdrop === 1'b1) drops++;
      total++; if (drops !== 1) begin bad++; $display("FAIL abort_drop_pulses got=%0d want=1", drops); end
      put(1'b0, 1'b1);
      put(1'b1, 1'b1);
      total++; if (bus.wrusedw !== 11'd2) begin bad++; $display("FAIL abort_used2 got=%0d want=2", bus.wrusedw); end
      bus.rdreq = 1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         exp_w = sb.pop_front();
         total++;
         if ({bus.rdeop, bus.q} !== exp_w) begin bad++; $display("FAIL abort_q r%0d got=%h want=%h", i, {bus.rdeop, bus.q}, exp_w); end
      end
      bus.rdreq = 0;
      total++; if (bus.rdempty !== 1'b1) begin bad++; $display("FAIL abort_empty got=%b want=1", bus.rdempty); end
      // Abort together with an EOP word: nothing commits
      bus.wrreq = 1; bus.wreop = 1; bus.wrabort = 1; bus.data = rnd_word();
      cyc();
      idle();
      total++; if (bus.pktcnt !== 11'd0 || bus.rdempty !== 1'b1 || bus.wrusedw !== 11'd0) begin
         bad++; $display("FAIL abort_vs_eop pktcnt=%0d rdempty=%b used=%0d want 0/1/0", bus.pktcnt, bus.rdempty, bus.wrusedw);
      end
      cyc();
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         put((i % 128) == 127, 1'b1);
         total++;
         if (bus.wrafull !== ((i + 1) >= AFULL_TH)) begin bad++; $display("FAIL fill_afull n=%0d got=%b", i + 1, bus.wrafull); end
      end
      total++; if (bus.wrfull !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", bus.wrfull); end
      total++; if (bus.wrusedw !== 11'd1024) begin bad++; $display("FAIL fill_used got=%0d want=1024", bus.wrusedw); end
      put(1'b1, 1'b0);
      total++; if (bus.wrusedw !== 11'd1024 || bus.pktcnt !== 11'd8) begin
         bad++; $display("FAIL fill_extra used=%0d pktcnt=%0d want 1024/8", bus.wrusedw, bus.pktcnt);
      end
      bus.rdreq = 1;
      for (int i = 0; i < DEPTH; i++) begin
         cyc();
         exp_w = sb.pop_front();
         total++;
         if ({bus.rdeop, bus.q} !== exp_w) begin bad++; $display("FAIL fill_q r%0d got=%h want=%h", i, {bus.rdeop, bus.q}, exp_w); end
      end
      bus.rdreq = 0;
      total++; if (bus.rdempty !== 1'b1 || bus.wrusedw !== 11'd0 || bus.pktcnt !== 11'd0) begin
         bad++; $display("FAIL fill_drained rdempty=%b used=%0d pktcnt=%0d", bus.rdempty, bus.wrusedw, bus.pktcnt);
      end
   endtask

   task automatic test_oversize();
      for (int i = 0; i < 1100; i++) begin
         put(i == 1099, 1'b0);
         total++;
         if (bus.rdempty !== 1'b1) begin bad++; $display("FAIL ovs_rdempty w%0d got=%b want=1", i, bus.rdempty); end
         if (i == 1098) begin
            total++; if (bus.wrusedw !== 11'd1024) begin bad++; $display("FAIL ovs_used_full got=%0d want=1024", bus.wrusedw); end
         end
      end
`ifdef TXFIFO_PKT_DROP_EN
      total++; if (bus.wrdrop !== 1'b1) begin bad++; $display("FAIL ovs_drop got=%b want=1", bus.wrdrop); end
      total++; if (bus.wrusedw !== 11'd0) begin bad++; $display("FAIL ovs_used0 got=%0d want=0", bus.wrusedw); end
`else
      total++; if (bus.wrfull !== 1'b1 || bus.wrusedw !== 11'd1024) begin
         bad++; $display("FAIL ovs_stall full=%b used=%0d want 1/1024", bus.wrfull, bus.wrusedw);
      end
      total++; if (bus.wrdrop !== 1'b0) begin bad++; $display("FAIL ovs_nodrop got=%b want=0", bus.wrdrop); end
      bus.wrabort = 1; cyc(); bus.wrabort = 0;
      total++; if (bus.wrusedw !== 11'd0 || bus.wrdrop !== 1'b1) begin
         bad++; $display("FAIL ovs_abort used=%0d drop=%b want 0/1", bus.wrusedw, bus.wrdrop);
      end
`endif
      cyc();
      total++; if (bus.rdempty !== 1'b1 || bus.pktcnt !== 11'd0) begin
         bad++; $display("FAIL ovs_end rdempty=%b pktcnt=%0d", bus.rdempty, bus.pktcnt);
      end
   endtask

   task automatic test_back_to_back();
      put(1'b0, 1'b1);
      put(1'b1, 1'b1);
      put(1'b0, 1'b1);
      bus.rdreq = 1;
      cyc();
      exp_w = sb.pop_front();
      total++; if ({bus.rdeop, bus.q} !== exp_w) begin bad++; $display("FAIL b2b_a0 got=%h want=%h", {bus.rdeop, bus.q}, exp_w); end
      // EOP read of A and commit of B in one cycle
      bus.wrreq = 1; bus.wreop = 1; bus.data = rnd_word();
      sb.push_back({1'b1, bus.data});
      cyc();
      bus.wrreq = 0; bus.wreop = 0;
      exp_w = sb.pop_front();
      total++; if ({bus.rdeop, bus.q} !== exp_w) begin bad++; $display("FAIL b2b_a1 got=%h want=%h", {bus.rdeop, bus.q}, exp_w); end
      total++; if (bus.pktcnt !== 11'd1) begin bad++; $display("FAIL b2b_pktcnt got=%0d want=1", bus.pktcnt); end
      for (int i = 0; i < 2; i++) begin
         cyc();
         exp_w = sb.pop_front();
         total++;
         if ({bus.rdeop, bus.q} !== exp_w) begin bad++; $display("FAIL b2b_b r%0d got=%h want=%h", i, {bus.rdeop, bus.q}, exp_w); end
      end
      bus.rdreq = 0;
      total++; if (bus.pktcnt !== 11'd0 || bus.rdempty !== 1'b1) begin
         bad++; $display("FAIL b2b_end pktcnt=%0d rdempty=%b", bus.pktcnt, bus.rdempty);
      end
   endtask

   task automatic test_wrap();
      int wr_n, rd_n, left, errs;
      logic did_rd;
      wr_n = 0; rd_n = 0; errs = 0;
      left = $urandom_range(16, 1);
      for (int c = 0; c < 20000 && rd_n < 3000; c++) begin
         bus.wrreq = (wr_n < 3000) && !bus.wrfull && ($urandom_range(3, 0) != 0);
         if (bus.wrreq) begin
            bus.data = rnd_word();
            bus.wreop = (left == 1) || (wr_n == 2999);
            sb.push_back({bus.wreop, bus.data});
            wr_n++;
            left = (left == 1) ? $urandom_range(16, 1) : left - 1;
         end
         bus.rdreq = !bus.rdempty && ($urandom_range(3, 0) != 0);
         did_rd = bus.rdreq;
         cyc();
         if (did_rd) begin
            exp_w = sb.pop_front();
            rd_n++;
            total++;
            if ({bus.rdeop, bus.q} !== exp_w) begin
               bad++; errs++;
               if (errs < 5) $display("FAIL wrap_q r%0d got=%h want=%h", rd_n, {bus.rdeop, bus.q}, exp_w);
            end
         end
      end
      idle();
      total++; if (rd_n !== 3000) begin bad++; $display("FAIL wrap_timeout read=%0d want=3000", rd_n); end
      total++; if (bus.rdempty !== 1'b1 || bus.pktcnt !== 11'd0) begin
         bad++; $display("FAIL wrap_end rdempty=%b pktcnt=%0d", bus.rdempty, bus.pktcnt);
      end
   endtask

   task automatic test_async_reset();
      put(1'b0, 1'b1);
      put(1'b1, 1'b1);
      put(1'b0, 1'b0);
      bus.rdreq = 1;
      cyc();
      exp_w = sb.pop_front();
      total++; if ({bus.rdeop, bus.q} !== exp_w) begin bad++; $display("FAIL arst_pre got=%h want=%h", {bus.rdeop, bus.q}, exp_w); end
      bus.wrreq = 1; bus.data = rnd_word();
      #2;
      reset_ = 0;
      #1;
      total++; if (bus.q !== '0) begin bad++; $display("FAIL arst_q got=%h want=0", bus.q); end
      total++; if (bus.rdeop !== 1'b0 || bus.rdempty !== 1'b1 || bus.wrfull !== 1'b0 || bus.wrafull !== 1'b0) begin
         bad++; $display("FAIL arst_flags rdeop=%b rdempty=%b wrfull=%b wrafull=%b want 0/1/0/0", bus.rdeop, bus.rdempty, bus.wrfull, bus.wrafull);
      end
      total++; if (bus.wrusedw !== '0 || bus.pktcnt !== '0 || bus.wrdrop !== 1'b0) begin
         bad++; $display("FAIL arst_counts used=%0d pktcnt=%0d drop=%b want 0/0/0", bus.wrusedw, bus.pktcnt, bus.wrdrop);
      end
      idle();
      sb.delete();
      cyc();
      reset_ = 1;
      cyc();
      put(1'b1, 1'b1);
      bus.rdreq = 1; cyc(); bus.rdreq = 0;
      exp_w = sb.pop_front();
      total++; if ({bus.rdeop, bus.q} !== exp_w) begin bad++; $display("FAIL arst_post got=%h want=%h", {bus.rdeop, bus.q}, exp_w); end
   endtask

   initial begin
      idle();
      test_reset();
      test_basic_packet();
      test_abort();
      test_fill();
      test_oversize();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
